// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage constants: register file geometry and the byte-load
// zero-extension helper, also imported by the MEM and decode stages.
package wb_stage_pkg;

  localparam int NREG      = 8;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 3;
  localparam int NRD       = 4;
  localparam int BYTE_W    = 8;
  localparam int ZEXT_W    = XLEN - BYTE_W;

  function automatic logic [XLEN-1:0] zextByte(input logic [BYTE_W-1:0] b);
    return {{ZEXT_W{1'b0}}, b};
  endfunction

endpackage

// File: rtl/regfile_8x32_2w4r.sv
// 8x32 architectural register file: two write ports (ALU, MEM) with MEM-wins
// arbitration and four combinational read ports with write-through bypass.
module regfile_8x32_2w4r
  import wb_stage_pkg::*;
#(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic                          i_aluWe,
  input  logic [REG_IDX_W-1:0]          i_aluRd,
  input  logic [XLEN-1:0]               i_aluData,
  input  logic                          i_memWe,
  input  logic [REG_IDX_W-1:0]          i_memRd,
  input  logic [XLEN-1:0]               i_memData,
  input  logic [NRD-1:0][REG_IDX_W-1:0] i_raddr,
  output logic [NRD-1:0][XLEN-1:0]      o_rdata
);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_aluWrite;
  logic            w_memWrite;

  // The MEM slot is later in bundle order, so it suppresses an ALU write to the same register.
  assign w_memWrite = i_memWe && !(R0_ZERO && (i_memRd == '0));
  assign w_aluWrite = i_aluWe && !(R0_ZERO && (i_aluRd == '0))
                      && !(i_memWe && (i_memRd == i_aluRd));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_aluWrite) r_regs[i_aluRd] <= i_aluData;
      if (w_memWrite) r_regs[i_memRd] <= i_memData;
    end
  end

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      o_rdata[p] = r_regs[i_raddr[p]];
      if (R0_ZERO && (i_raddr[p] == '0)) begin
        o_rdata[p] = '0;
      end else if (i_memWe && (i_memRd == i_raddr[p])) begin
        o_rdata[p] = i_memData;
      end else if (i_aluWe && (i_aluRd == i_raddr[p])) begin
        o_rdata[p] = i_aluData;
      end
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage of the two-slot VLIW pipeline: commits ALU/MEM results,
// serves decode reads, and tracks outstanding loads per register.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p4_alu_we,
  input  logic [REG_IDX_W-1:0] p4_alu_rd,
  input  logic [XLEN-1:0]      p4_alu_aluOut,
  input  logic                 p4_mem_we,
  input  logic [REG_IDX_W-1:0] p4_mem_rd,
  input  logic [XLEN-1:0]      p4_mem_out,
  input  logic [REG_IDX_W-1:0] rs_addr0,
  input  logic [REG_IDX_W-1:0] rs_addr1,
  input  logic [REG_IDX_W-1:0] rs_addr2,
  input  logic [REG_IDX_W-1:0] rs_addr3,
  output logic [XLEN-1:0]      rs_data0,
  output logic [XLEN-1:0]      rs_data1,
  output logic [XLEN-1:0]      rs_data2,
  output logic [XLEN-1:0]      rs_data3,
  input  logic                 id_load_issue,
  input  logic [REG_IDX_W-1:0] id_load_rd,
  output logic [NREG-1:0]      busy,
  output logic                 wb_conflict
);

  logic [XLEN-1:0]               w_memWdata;
  logic                          w_unusedMemHi;
  logic [NRD-1:0][REG_IDX_W-1:0] w_raddr;
  logic [NRD-1:0][XLEN-1:0]      w_rdata;
  logic [NREG-1:0]               r_busy;
  logic [NREG-1:0]               w_busyNext;
  logic                          r_wbConflict;
  logic                          w_dualConflict;

  // Byte loads only: the upper load bits are deliberately dropped.
  assign w_memWdata    = zextByte(p4_mem_out[BYTE_W-1:0]);
  assign w_unusedMemHi = ^p4_mem_out[XLEN-1:BYTE_W];

  assign w_raddr  = {rs_addr3, rs_addr2, rs_addr1, rs_addr0};
  assign rs_data0 = w_rdata[0];
  assign rs_data1 = w_rdata[1];
  assign rs_data2 = w_rdata[2];
  assign rs_data3 = w_rdata[3];

  regfile_8x32_2w4r #(
    .R0_ZERO (R0_ZERO)
  ) u_regfile (
    .clk       (clk),
    .i_rst_n   (reset),
    .i_aluWe   (p4_alu_we),
    .i_aluRd   (p4_alu_rd),
    .i_aluData (p4_alu_aluOut),
    .i_memWe   (p4_mem_we),
    .i_memRd   (p4_mem_rd),
    .i_memData (w_memWdata),
    .i_raddr   (w_raddr),
    .o_rdata   (w_rdata)
  );

  // Set after clear so a newly issued load to the same register stays outstanding.
  always_comb begin
    w_busyNext = r_busy;
    if (p4_mem_we) begin
      w_busyNext[p4_mem_rd] = 1'b0;
    end
    if (id_load_issue && !(R0_ZERO && (id_load_rd == '0))) begin
      w_busyNext[id_load_rd] = 1'b1;
    end
  end

  assign w_dualConflict = p4_alu_we && p4_mem_we && (p4_alu_rd == p4_mem_rd)
                          && !(R0_ZERO && (p4_alu_rd == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy       <= '0;
      r_wbConflict <= 1'b0;
    end else begin
      r_busy       <= w_busyNext;
      r_wbConflict <= w_dualConflict;
    end
  end

  assign busy        = r_busy;
  assign wb_conflict = r_wbConflict;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expectations are queued as stimulus is
// driven and drained against the DUT between clock edges.
module tb_wb_stage;

  localparam int K_RS0  = 0;
  localparam int K_RS1  = 1;
  localparam int K_RS2  = 2;
  localparam int K_RS3  = 3;
  localparam int K_BUSY = 4;
  localparam int K_CONF = 5;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } sbEntry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        p4_alu_we;
  logic [2:0]  p4_alu_rd;
  logic [31:0] p4_alu_aluOut;
  logic        p4_mem_we;
  logic [2:0]  p4_mem_rd;
  logic [31:0] p4_mem_out;
  logic [2:0]  rs_addr0, rs_addr1, rs_addr2, rs_addr3;
  logic [31:0] rs_data0, rs_data1, rs_data2, rs_data3;
  logic        id_load_issue;
  logic [2:0]  id_load_rd;
  logic [7:0]  busy;
  logic        wb_conflict;

  sbEntry_t sbQueue[$];
  int       compareCount  = 0;
  int       mismatchCount = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk           (clk),
    .reset         (reset),
    .p4_alu_we     (p4_alu_we),
    .p4_alu_rd     (p4_alu_rd),
    .p4_alu_aluOut (p4_alu_aluOut),
    .p4_mem_we     (p4_mem_we),
    .p4_mem_rd     (p4_mem_rd),
    .p4_mem_out    (p4_mem_out),
    .rs_addr0      (rs_addr0),
    .rs_addr1      (rs_addr1),
    .rs_addr2      (rs_addr2),
    .rs_addr3      (rs_addr3),
    .rs_data0      (rs_data0),
    .rs_data1      (rs_data1),
    .rs_data2      (rs_data2),
    .rs_data3      (rs_data3),
    .id_load_issue (id_load_issue),
    .id_load_rd    (id_load_rd),
    .busy          (busy),
    .wb_conflict   (wb_conflict)
  );

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_RS0:   return rs_data0;
      K_RS1:   return rs_data1;
      K_RS2:   return rs_data2;
      K_RS3:   return rs_data3;
      K_BUSY:  return {24'h0, busy};
      default: return {31'h0, wb_conflict};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic expectValue(input string tag, input int kind, input logic [31:0] exp);
    sbEntry_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sbQueue.push_back(e);
  endtask

  task automatic drainScoreboard();
    sbEntry_t e;
    #1;
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkOutput(e.tag, observe(e.kind), e.exp);
    end
  endtask

  task automatic applyStimulus(input logic aluWe, input logic [2:0] aluRd, input logic [31:0] aluData,
                               input logic memWe, input logic [2:0] memRd, input logic [31:0] memData,
                               input logic ldIssue, input logic [2:0] ldRd);
    p4_alu_we     = aluWe;
    p4_alu_rd     = aluRd;
    p4_alu_aluOut = aluData;
    p4_mem_we     = memWe;
    p4_mem_rd     = memRd;
    p4_mem_out    = memData;
    id_load_issue = ldIssue;
    id_load_rd    = ldRd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    rs_addr0 = 3'd1; rs_addr1 = 3'd3; rs_addr2 = 3'd5; rs_addr3 = 3'd7;

    @(negedge clk);
    expectValue("rst_rs0", K_RS0, 32'h0);
    expectValue("rst_rs1", K_RS1, 32'h0);
    expectValue("rst_rs2", K_RS2, 32'h0);
    expectValue("rst_rs3", K_RS3, 32'h0);
    expectValue("rst_busy", K_BUSY, 32'h0);
    expectValue("rst_conf", K_CONF, 32'h0);
    drainScoreboard();
    @(negedge clk);
    reset = 1'b1;

    // Commit r3 and a load issue, then lose a later r3 write to a mid-cycle reset.
    rs_addr0 = 3'd3;
    applyStimulus(1'b1, 3'd3, 32'h0000AAAA, 1'b0, 3'd0, 32'h0, 1'b1, 3'd1);
    nextCycle();
    idle();
    expectValue("pre_rst_r3", K_RS0, 32'h0000AAAA);
    expectValue("pre_rst_busy", K_BUSY, 32'h02);
    drainScoreboard();
    applyStimulus(1'b1, 3'd3, 32'h00001234, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    #2 reset = 1'b0;
    nextCycle();
    idle();
    reset = 1'b1;
    expectValue("rst_inflight_r3", K_RS0, 32'h0);
    expectValue("rst_busy_clr", K_BUSY, 32'h0);
    drainScoreboard();

    rs_addr0 = 3'd2;
    applyStimulus(1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    expectValue("alu_bypass_r2", K_RS0, 32'hDEADBEEF);
    drainScoreboard();
    nextCycle();
    idle();
    expectValue("alu_stored_r2", K_RS0, 32'hDEADBEEF);
    drainScoreboard();

    rs_addr1 = 3'd5;
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 3'd5, 32'hFFFFFF9A, 1'b0, 3'd0);
    expectValue("mem_bypass_r5", K_RS1, 32'h0000009A);
    drainScoreboard();
    nextCycle();
    idle();
    expectValue("mem_stored_r5", K_RS1, 32'h0000009A);
    drainScoreboard();

    rs_addr2 = 3'd4;
    applyStimulus(1'b1, 3'd4, 32'h11111111, 1'b1, 3'd4, 32'hABCDEF22, 1'b0, 3'd0);
    expectValue("dual_bypass_r4", K_RS2, 32'h00000022);
    expectValue("dual_conf_pre", K_CONF, 32'h0);
    drainScoreboard();
    nextCycle();
    idle();
    expectValue("dual_stored_r4", K_RS2, 32'h00000022);
    expectValue("dual_conf_pulse", K_CONF, 32'h1);
    drainScoreboard();
    nextCycle();
    expectValue("dual_conf_end", K_CONF, 32'h0);
    drainScoreboard();

    // Split-slot write: ALU to r1 and MEM to r7 in one bundle, no conflict.
    rs_addr3 = 3'd1;
    rs_addr1 = 3'd7;
    applyStimulus(1'b1, 3'd1, 32'hCAFEF00D, 1'b1, 3'd7, 32'h00000177, 1'b0, 3'd0);
    nextCycle();
    idle();
    expectValue("split_r1", K_RS3, 32'hCAFEF00D);
    expectValue("split_r7", K_RS1, 32'h00000077);
    expectValue("split_conf", K_CONF, 32'h0);
    drainScoreboard();

    rs_addr3 = 3'd0;
    applyStimulus(1'b1, 3'd0, 32'h00000055, 1'b1, 3'd0, 32'h00000066, 1'b0, 3'd0);
    expectValue("r0_bypass", K_RS3, 32'h0);
    drainScoreboard();
    nextCycle();
    idle();
    expectValue("r0_stored", K_RS3, 32'h0);
    expectValue("r0_no_conf", K_CONF, 32'h0);
    expectValue("r2_retained", K_RS0, 32'hDEADBEEF);
    drainScoreboard();

    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd6);
    nextCycle();
    idle();
    expectValue("sb_set6", K_BUSY, 32'h40);
    drainScoreboard();
    applyStimulus(1'b1, 3'd6, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0);
    nextCycle();
    idle();
    expectValue("sb_alu_r0issue", K_BUSY, 32'h40);
    drainScoreboard();
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 3'd6, 32'h00000001, 1'b0, 3'd0);
    nextCycle();
    idle();
    expectValue("sb_clear6", K_BUSY, 32'h00);
    drainScoreboard();
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd6);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 3'd6, 32'h00000002, 1'b1, 3'd6);
    nextCycle();
    idle();
    expectValue("sb_set_wins", K_BUSY, 32'h40);
    drainScoreboard();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the two-slot (ALU slot + MEM slot) VLIW pipeline.
- Consumes the MEM/WB pipeline register outputs (p4_*) and commits results into an 8-entry x 32-bit architectural register file.
- Provides four combinational read ports to the decode stage, with write-through bypass.
- Keeps a load scoreboard (busy bits) so decode can stall on registers with an outstanding load.

Parameters:
- NREG, 8, number of architectural registers (index width 3; fixed by the bundle format).
- XLEN, 32, register data width.
- R0_ZERO, 1, when 1, register 0 reads as 0 and writes to it are discarded.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- p4_alu_we  in  1  ALU-slot write enable.
- p4_alu_rd  in  3  ALU-slot destination register.
- p4_alu_aluOut  in  32  ALU-slot result.
- p4_mem_we  in  1  MEM-slot (load) write enable.
- p4_mem_rd  in  3  MEM-slot destination register.
- p4_mem_out  in  32  load data; only bits [7:0] are meaningful (byte load).
- rs_addr0..rs_addr3  in  3 each  decode read addresses (slot0 rs/rt, slot1 rs/rt).
- rs_data0..rs_data3  out  32 each  read data.
- id_load_issue  in  1  decode issues a load this cycle.
- id_load_rd  in  3  destination of the issued load.
- busy  out  8  per-register outstanding-load flag.
- wb_conflict  out  1  registered; pulses for one cycle after a same-register dual write.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers cleared to 0; busy=8'h00; wb_conflict=0.
  - Read ports are then combinational and return 0.
  - Reset asserted mid-operation discards any in-flight write of that cycle.
- Load data: mem_wdata = {24'h0, p4_mem_out[7:0]}; bits [31:8] of p4_mem_out are ignored.
- Commit:
  - On the rising edge, if p4_alu_we, then reg[p4_alu_rd] <= p4_alu_aluOut.
  - If p4_mem_we, then reg[p4_mem_rd] <= mem_wdata.
  - Write latency is one edge.
- Same destination on both slots (both we, rd equal): MEM slot wins (later in bundle order). The ALU value is dropped and wb_conflict=1 on the following cycle.
- R0_ZERO=1: writes with rd=0 are ignored (no conflict flag if rd=0); rs_data for addr 0 is always 0.
- Reads (combinational), priority order:
  1. addr==0 and R0_ZERO gives 0.
  2. Else, if p4_mem_we and p4_mem_rd==addr, return mem_wdata.
  3. Else, if p4_alu_we and p4_alu_rd==addr, return p4_alu_aluOut.
  4. Else, reg[addr].
  - So decode sees the value being written in the same cycle.
- Scoreboard:
  - On the edge, busy[p4_mem_rd] is cleared if p4_mem_we.
  - busy[id_load_rd] is set if id_load_issue.
  - Set and clear of the same register in the same cycle: set wins (a newer load is outstanding).
  - id_load_rd=0 with R0_ZERO never sets busy[0].
  - ALU writes do not touch busy.
- No stall input: this stage always accepts and commits every cycle.

Decomposition:
- Shared package: NREG, XLEN, REG_IDX_W=3, and the byte zero-extend width constant, also used by the MEM and decode stages.
- One natural sub-module: regfile_8x32_2w4r, holding the storage, dual-write arbitration and bypassing read muxes.
- Scoreboard and conflict flag stay in wb_stage.

Test Plan:
- Reset, then read all ports: rs_data*=0 and busy=0. Assert reset during a write of r3=0x1234: after release, r3 reads 0.
- ALU write r2=0xDEADBEEF with rs_addr0=2 in the same cycle: rs_data0=0xDEADBEEF combinationally; next cycle it is still 0xDEADBEEF from storage.
- MEM write r5 with p4_mem_out=0xFFFFFF9A: r5 reads 0x0000009A.
- Dual write to r4 (ALU 0x11111111, MEM byte 0x22): r4=0x00000022, and wb_conflict=1 for exactly one cycle.
- Writes to r0 (ALU 0x55, MEM 0x66): r0 reads 0, and no wb_conflict.
- Scoreboard: id_load_issue rd=6 gives busy=8'h40. A later p4_mem_we rd=6 clears it to 8'h00. A simultaneous issue rd=6 and writeback rd=6 keeps busy[6]=1.
